// File: rtl/ysyx_22041752_div_ctrl.sv
// rtl/ysyx_22041752_div_ctrl.sv - radix-2 shift-subtract divide sequencer for RV64M div/rem (word forms included)
// Optional feature macro: YSYX_22041752_DIV_EARLY_EN (skip CALC when |divisor| > |dividend|).
module ysyx_22041752_div_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            div_signed,
    input  logic            op_rem,
    input  logic            res_sext,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int HALF = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_CALC = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q,     state_d;
    logic [XLEN-1:0]  x_q,         x_d;
    logic [XLEN-1:0]  y_q,         y_d;
    logic             signed_q,    signed_d;
    logic             op_rem_q,    op_rem_d;
    logic             word_q,      word_d;
    logic [XLEN-1:0]  quo_q,       quo_d;
    logic [XLEN-1:0]  rem_q,       rem_d;
    logic [XLEN-1:0]  ay_q,        ay_d;
    logic             q_neg_q,     q_neg_d;
    logic             r_neg_q,     r_neg_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [XLEN-1:0]  result_q,    result_d;
    logic             out_valid_q, out_valid_d;
    logic             div_ready_q, div_ready_d;
    logic             busy_q,      busy_d;

    logic [XLEN-1:0]  xe;
    logic [XLEN-1:0]  ye;
    logic [XLEN-1:0]  ax;
    logic [XLEN-1:0]  ay;
    logic [XLEN-1:0]  min_w;
    logic [CNT_W-1:0] w_iter;
    logic             sx;
    logic             sy;
    logic             spec_div0;
    logic             spec_ovf;
    logic             early_hit;

    logic [XLEN:0]    trial;
    logic [XLEN:0]    diff;

    logic [XLEN-1:0]  q_fix;
    logic [XLEN-1:0]  r_fix;
    logic [XLEN-1:0]  pick;
    logic [XLEN-1:0]  post_res;

    // Operand conditioning for PRE: word-form extension, magnitudes and special-case detection
    always_comb begin
        if (word_q) begin
            xe     = {{(XLEN-HALF){signed_q & x_q[HALF-1]}}, x_q[HALF-1:0]};
            ye     = {{(XLEN-HALF){signed_q & y_q[HALF-1]}}, y_q[HALF-1:0]};
            min_w  = {{(XLEN-HALF+1){1'b1}}, {(HALF-1){1'b0}}};
            w_iter = CNT_W'(HALF);
        end else begin
            xe     = x_q;
            ye     = y_q;
            min_w  = {1'b1, {(XLEN-1){1'b0}}};
            w_iter = CNT_W'(XLEN);
        end
        sx        = signed_q & xe[XLEN-1];
        sy        = signed_q & ye[XLEN-1];
        ax        = sx ? -xe : xe;
        ay        = sy ? -ye : ye;
        spec_div0 = (ye == '0);
        spec_ovf  = signed_q & (xe == min_w) & (&ye);
`ifdef YSYX_22041752_DIV_EARLY_EN
        early_hit = (ay > ax);
`else
        early_hit = 1'b0;
`endif
    end

    // One restoring-division step: bring in the next dividend bit and trial-subtract |y|
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]};
        diff  = trial - {1'b0, ay_q};
    end

    // Result shaping for POST: restore signs, pick quotient or remainder, sign-extend word ops
    always_comb begin
        q_fix    = q_neg_q ? -quo_q : quo_q;
        r_fix    = r_neg_q ? -rem_q : rem_q;
        pick     = op_rem_q ? r_fix : q_fix;
        post_res = word_q ? {{(XLEN-HALF){pick[HALF-1]}}, pick[HALF-1:0]} : pick;
    end

    // Sequencer next-state: accept, prepare, iterate, fix up, hold result; flush overrides all
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        signed_d = signed_q;
        op_rem_d = op_rem_q;
        word_d   = word_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        ay_d     = ay_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (div_valid && !flush) begin
                    x_d      = dividend;
                    y_d      = divisor;
                    signed_d = div_signed;
                    op_rem_d = op_rem;
                    word_d   = res_sext;
                    state_d  = S_PRE;
                end
            end
            S_PRE: begin
                if (spec_div0 || spec_ovf) begin
                    // Final values go straight through POST with sign fix-up disabled
                    quo_d   = spec_div0 ? '1 : min_w;
                    rem_d   = spec_div0 ? xe : '0;
                    q_neg_d = 1'b0;
                    r_neg_d = 1'b0;
                    state_d = S_POST;
                end else if (early_hit) begin
                    // Quotient is already known to be zero; a zero count tells CALC to pass through
                    quo_d   = '0;
                    rem_d   = ax;
                    ay_d    = ay;
                    q_neg_d = sx ^ sy;
                    r_neg_d = sx;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end else begin
                    // Word ops park the 32-bit magnitude in the top half so its MSB is shifted out first
                    quo_d   = word_q ? (ax << (XLEN-HALF)) : ax;
                    rem_d   = '0;
                    ay_d    = ay;
                    q_neg_d = sx ^ sy;
                    r_neg_d = sx;
                    cnt_d   = w_iter;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    state_d = S_POST;
                end else begin
                    rem_d = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                result_d = post_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end

        out_valid_d = (state_d == S_DONE);
        div_ready_d = (state_d == S_IDLE);
        busy_d      = ~div_ready_d;
    end

    // State, datapath and registered handshake outputs; reset returns to an idle, ready controller
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            signed_q    <= 1'b0;
            op_rem_q    <= 1'b0;
            word_q      <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            ay_q        <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            div_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            signed_q    <= signed_d;
            op_rem_q    <= op_rem_d;
            word_q      <= word_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            ay_q        <= ay_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            div_ready_q <= div_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign div_ready = div_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
